// File: rtl/uart_frame_rx_if.sv
// Bus bundle between a UART byte source / packet consumer and uart_frame_rx.
// The master drives bytes and pkt_ready; the slave (the receiver) drives the packet and status.
interface uart_frame_rx_if #(
  parameter int N_PIX = 4
);
  logic                 data_rdy;
  logic [7:0]           uart_byte;
  logic                 pkt_ready;
  logic                 pkt_valid;
  logic                 train;
  logic [8*N_PIX-1:0]   image;
  logic [7:0]           label;
  logic                 resend;
  logic                 err_csum;
  logic                 err_frame;
  logic                 err_timeout;
  logic                 busy;

  modport master (
    output data_rdy, uart_byte, pkt_ready,
    input  pkt_valid, train, image, label, resend, err_csum, err_frame, err_timeout, busy
  );

  modport slave (
    input  data_rdy, uart_byte, pkt_ready,
    output pkt_valid, train, image, label, resend, err_csum, err_frame, err_timeout, busy
  );
endinterface

// File: rtl/uart_frame_rx.sv
// Frame receiver: START 0xFF, mode, N_PIX image bytes, label, checksum, STOP 0xBB.
// Checksum failures trigger resend requests up to MAX_RESEND times before the frame is dropped.
module uart_frame_rx #(
  parameter int N_PIX      = 4,
  parameter int MAX_RESEND = 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic            uart_sampling_clk,
  input  logic            rst,
  uart_frame_rx_if.slave  bus
);

  localparam int IMG_W = 8 * N_PIX;
  localparam int CNT_W = (N_PIX < 2) ? 1 : $clog2(N_PIX);
  localparam int RTY_W = (MAX_RESEND < 1) ? 1 : $clog2(MAX_RESEND + 1);
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PIX - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RESEND);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, MODE, DATA, LABEL, CSUM, STOP, HOLD} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [7:0]         sum, sum_d;
  logic               csum_ok, csum_ok_d;
  logic [RTY_W-1:0]   retry, retry_d;
  logic [TMO_W-1:0]   idle_cnt, idle_cnt_d;
  logic [IMG_W-1:0]   image_q, image_d;
  logic [7:0]         label_q, label_d;
  logic               train_q, train_d;
  logic               pkt_valid_q, pkt_valid_d;
  logic               resend_q, resend_d;
  logic               err_csum_q, err_csum_d;
  logic               err_frame_q, err_frame_d;
  logic               err_timeout_q, err_timeout_d;
  logic               busy_q, busy_d;
  logic               timed;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  always_ff @(posedge uart_sampling_clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      sum           <= '0;
      csum_ok       <= 1'b0;
      retry         <= '0;
      idle_cnt      <= '0;
      image_q       <= '0;
      label_q       <= '0;
      train_q       <= 1'b0;
      pkt_valid_q   <= 1'b0;
      resend_q      <= 1'b0;
      err_csum_q    <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      sum           <= sum_d;
      csum_ok       <= csum_ok_d;
      retry         <= retry_d;
      idle_cnt      <= idle_cnt_d;
      image_q       <= image_d;
      label_q       <= label_d;
      train_q       <= train_d;
      pkt_valid_q   <= pkt_valid_d;
      resend_q      <= resend_d;
      err_csum_q    <= err_csum_d;
      err_frame_q   <= err_frame_d;
      err_timeout_q <= err_timeout_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    sum_d         = sum;
    csum_ok_d     = csum_ok;
    retry_d       = retry;
    image_d       = image_q;
    label_d       = label_q;
    train_d       = train_q;
    pkt_valid_d   = pkt_valid_q;
    resend_d      = 1'b0;
    err_csum_d    = 1'b0;
    err_frame_d   = 1'b0;
    err_timeout_d = 1'b0;
    timed         = (state inside {MODE, DATA, LABEL, CSUM, STOP});

    if (bus.data_rdy || !timed) idle_cnt_d = '0;
    else                        idle_cnt_d = idle_cnt + 1'b1;

    if (timed && !bus.data_rdy && idle_cnt == TMO_LAST) begin
      err_timeout_d = 1'b1;
      state_d       = IDLE;
      idle_cnt_d    = '0;
    end else begin
      case (state)
        IDLE: if (bus.data_rdy && bus.uart_byte == 8'hFF) begin
          state_d = MODE;
          cnt_d   = '0;
          sum_d   = '0;
        end
        MODE: if (bus.data_rdy) begin
          if (bus.uart_byte == 8'hF0) begin
            train_d = 1'b1;
            state_d = DATA;
          end else if (bus.uart_byte == 8'h0F) begin
            train_d = 1'b0;
            state_d = DATA;
          end else begin
            err_frame_d = 1'b1;
            state_d     = IDLE;
          end
        end
        DATA: if (bus.data_rdy) begin
          image_d = (image_q << 8) | IMG_W'(bus.uart_byte);
          sum_d   = csum_add(sum, bus.uart_byte);
          if (cnt == CNT_LAST) begin
            cnt_d   = '0;
            state_d = LABEL;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        LABEL: if (bus.data_rdy) begin
          label_d = bus.uart_byte;
          sum_d   = csum_add(sum, bus.uart_byte);
          state_d = CSUM;
        end
        CSUM: if (bus.data_rdy) begin
          csum_ok_d = (bus.uart_byte == sum);
          state_d   = STOP;
        end
        STOP: if (bus.data_rdy) begin
          state_d = IDLE;
          if (bus.uart_byte != 8'hBB) begin
            err_frame_d = 1'b1;
          end else if (csum_ok) begin
            pkt_valid_d = 1'b1;
            retry_d     = '0;
            state_d     = HOLD;
          end else if (retry < RTY_MAX) begin
            resend_d = 1'b1;
            retry_d  = retry + 1'b1;
          end else begin
            err_csum_d = 1'b1;
            retry_d    = '0;
          end
        end
        HOLD: if (pkt_valid_q && bus.pkt_ready) begin
          pkt_valid_d = 1'b0;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.pkt_valid   = pkt_valid_q;
  assign bus.train       = train_q;
  assign bus.image       = image_q;
  assign bus.label       = label_q;
  assign bus.resend      = resend_q;
  assign bus.err_csum    = err_csum_q;
  assign bus.err_frame   = err_frame_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed and randomized frames for uart_frame_rx, checked against a frame-level reference model.
module tb_uart_frame_rx;
  localparam int N_PIX      = 4;
  localparam int MAX_RESEND = 1;
  localparam int TIMEOUT    = 16;
  localparam int IW         = 8 * N_PIX;
  localparam int K_PKT = 0, K_RESEND = 1, K_CSUM = 2, K_FRAME = 3;

  logic uart_sampling_clk = 1'b0;
  logic rst = 1'b1;
  always #5 uart_sampling_clk = ~uart_sampling_clk;

  uart_frame_rx_if #(.N_PIX(N_PIX)) bus();

  uart_frame_rx #(.N_PIX(N_PIX), .MAX_RESEND(MAX_RESEND), .TIMEOUT(TIMEOUT)) dut (
    .uart_sampling_clk (uart_sampling_clk),
    .rst               (rst),
    .bus               (bus)
  );

  int checks = 0;
  int errors = 0;
  int n_pkt = 0, n_resend = 0, n_csum = 0, n_frame = 0, n_tmo = 0, n_unstable = 0;
  logic          pv_prev = 1'b0;
  logic [IW-1:0] img_prev = '0, last_img = '0;
  logic [7:0]    lab_prev = '0, last_lab = '0;
  logic          tr_prev = 1'b0, last_train = 1'b0;

  // Event monitor: counts high cycles of each pulse and captures each delivered packet.
  always @(negedge uart_sampling_clk) begin
    if (bus.resend)      n_resend <= n_resend + 1;
    if (bus.err_csum)    n_csum   <= n_csum + 1;
    if (bus.err_frame)   n_frame  <= n_frame + 1;
    if (bus.err_timeout) n_tmo    <= n_tmo + 1;
    if (bus.pkt_valid && !pv_prev) begin
      n_pkt      <= n_pkt + 1;
      last_img   <= bus.image;
      last_lab   <= bus.label;
      last_train <= bus.train;
    end
    if (bus.pkt_valid && pv_prev &&
        (bus.image !== img_prev || bus.label !== lab_prev || bus.train !== tr_prev))
      n_unstable <= n_unstable + 1;
    pv_prev  <= bus.pkt_valid;
    img_prev <= bus.image;
    lab_prev <= bus.label;
    tr_prev  <= bus.train;
  end

  logic [7:0] fq[$];
  int         m_retry = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge uart_sampling_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.data_rdy  = 1'b1;
    bus.uart_byte = b;
    tick(1);
    bus.data_rdy  = 1'b0;
  endtask

  task automatic build(input logic [7:0] mode, input logic [IW-1:0] img, input logic [7:0] lab,
                       input logic [7:0] csum, input logic [7:0] stop);
    fq.delete();
    fq.push_back(8'hFF);
    fq.push_back(mode);
    if (mode == 8'hF0 || mode == 8'h0F) begin
      for (int i = 0; i < N_PIX; i++) fq.push_back(img[8*(N_PIX-1-i) +: 8]);
      fq.push_back(lab);
      fq.push_back(csum);
      fq.push_back(stop);
    end
  endtask

  function automatic logic [7:0] ref_sum(input logic [IW-1:0] img, input logic [7:0] lab);
    int s = lab;
    for (int i = 0; i < N_PIX; i++) s += img[8*i +: 8];
    return 8'(s % 256);
  endfunction

  // Frame-level outcome from the byte list in fq, tracking the retry budget across frames.
  task automatic model(output int kind, output logic [IW-1:0] eimg, output logic [7:0] elab,
                       output logic etrain);
    int s = 0;
    eimg   = '0;
    elab   = '0;
    etrain = (fq[1] == 8'hF0);
    if (fq[1] != 8'hF0 && fq[1] != 8'h0F) begin
      kind = K_FRAME;
      return;
    end
    for (int i = 0; i < N_PIX; i++) begin
      eimg = (eimg << 8) | IW'(fq[2+i]);
      s += fq[2+i];
    end
    elab = fq[2+N_PIX];
    s += elab;
    if (fq[4+N_PIX] != 8'hBB) kind = K_FRAME;
    else if ((s % 256) == int'(fq[3+N_PIX])) begin
      kind = K_PKT;
      m_retry = 0;
    end else if (m_retry < MAX_RESEND) begin
      kind = K_RESEND;
      m_retry++;
    end else begin
      kind = K_CSUM;
      m_retry = 0;
    end
  endtask

  task automatic send_fq(input int maxgap);
    for (int i = 0; i < fq.size(); i++) begin
      send_byte(fq[i]);
      if (i != fq.size() - 1) tick($urandom_range(maxgap, 0));
    end
  endtask

  task automatic run_frame(input string tag, input int maxgap, input int hold);
    int kind, s_pkt, s_res, s_csum, s_frm, s_tmo;
    logic [IW-1:0] eimg;
    logic [7:0]    elab;
    logic          etrain;
    s_pkt = n_pkt; s_res = n_resend; s_csum = n_csum; s_frm = n_frame; s_tmo = n_tmo;
    model(kind, eimg, elab, etrain);
    bus.pkt_ready = (hold == 0);
    send_fq(maxgap);
    if (hold > 0) begin
      tick(hold);
      bus.pkt_ready = 1'b1;
    end
    tick(2);
    check({tag, "_pkt"},    64'(n_pkt - s_pkt),     64'(kind == K_PKT));
    check({tag, "_resend"}, 64'(n_resend - s_res),  64'(kind == K_RESEND));
    check({tag, "_csum"},   64'(n_csum - s_csum),   64'(kind == K_CSUM));
    check({tag, "_frame"},  64'(n_frame - s_frm),   64'(kind == K_FRAME));
    check({tag, "_tmo"},    64'(n_tmo - s_tmo),     64'd0);
    check({tag, "_idle"},   64'(bus.busy),          64'd0);
    if (kind == K_PKT) begin
      check({tag, "_image"}, 64'(last_img),   64'(eimg));
      check({tag, "_label"}, 64'(last_lab),   64'(elab));
      check({tag, "_train"}, 64'(last_train), 64'(etrain));
    end
  endtask

  initial begin
    int            kind;
    logic [IW-1:0] eimg, img, held_img;
    logic [7:0]    elab, lab, mode, csum, stop;
    logic          etrain;

    bus.data_rdy  = 1'b0;
    bus.uart_byte = 8'h00;
    bus.pkt_ready = 1'b1;
    rst = 1'b1;
    tick(3);
    check("rst_pkt_valid", 64'(bus.pkt_valid), 64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    check("rst_image",     64'(bus.image),     64'd0);
    check("rst_flags",     64'({bus.resend, bus.err_csum, bus.err_frame, bus.err_timeout, bus.train}), 64'd0);
    rst = 1'b0;
    tick(1);

    // Good TRAIN frame: pkt_valid visible right after the STOP edge, gone one cycle later.
    build(8'hF0, 32'h01020304, 8'h02, 8'h0C, 8'hBB);
    model(kind, eimg, elab, etrain);
    send_fq(0);
    check("basic_pkt_valid", 64'(bus.pkt_valid), 64'd1);
    check("basic_image",     64'(bus.image),     64'h01020304);
    check("basic_label",     64'(bus.label),     64'h02);
    check("basic_train",     64'(bus.train),     64'd1);
    tick(1);
    check("basic_release",   64'(bus.pkt_valid), 64'd0);
    check("basic_idle",      64'(bus.busy),      64'd0);

    // Retry sequence: resend, then drop, then success.
    build(8'hF0, 32'h01020304, 8'h02, 8'h0B, 8'hBB); run_frame("retry1", 0, 0);
    build(8'hF0, 32'h01020304, 8'h02, 8'h0A, 8'hBB); run_frame("retry2", 0, 0);
    build(8'hF0, 32'h01020304, 8'h02, 8'h0C, 8'hBB); run_frame("retry3", 0, 0);

    // Bad mode byte, then a TEST frame with a bad STOP byte.
    send_byte(8'hFF);
    send_byte(8'h55);
    check("badmode_err", 64'(bus.err_frame), 64'd1);
    check("badmode_idle", 64'(bus.busy),     64'd0);
    tick(2);
    build(8'h0F, 32'h01020304, 8'h02, 8'h0C, 8'hAA); run_frame("badstop", 0, 0);

    // Inter-byte timeout.
    send_byte(8'hFF); send_byte(8'hF0); send_byte(8'h01);
    tick(TIMEOUT - 1);
    check("tmo_early", 64'(bus.err_timeout), 64'd0);
    check("tmo_busy",  64'(bus.busy),        64'd1);
    tick(1);
    check("tmo_pulse", 64'(bus.err_timeout), 64'd1);
    check("tmo_idle",  64'(bus.busy),        64'd0);
    tick(1);
    check("tmo_once",  64'(bus.err_timeout), 64'd0);

    // Consumer stalls: packet held, extra bytes dropped.
    build(8'h0F, 32'hA1B2C3D4, 8'h77, ref_sum(32'hA1B2C3D4, 8'h77), 8'hBB);
    model(kind, eimg, elab, etrain);
    bus.pkt_ready = 1'b0;
    send_fq(1);
    held_img = bus.image;
    for (int i = 0; i < 5; i++) begin
      send_byte((i == 0) ? 8'hFF : 8'(i * 37));
      check($sformatf("hold_valid%0d", i), 64'(bus.pkt_valid), 64'd1);
      check($sformatf("hold_image%0d", i), 64'(bus.image),     64'(eimg));
    end
    check("hold_label", 64'(bus.label), 64'(elab));
    check("hold_train", 64'(bus.train), 64'd0);
    bus.pkt_ready = 1'b1;
    tick(1);
    check("hold_release", 64'(bus.pkt_valid), 64'd0);
    check("hold_idle",    64'(bus.busy),      64'd0);
    check("hold_first",   64'(held_img),      64'(eimg));

    // Reset mid-frame after burning a retry: state, outputs and retry count all cleared.
    build(8'hF0, 32'h11223344, 8'h55, 8'h00, 8'hBB); run_frame("prerst", 0, 0);
    send_byte(8'hFF); send_byte(8'hF0); send_byte(8'h01); send_byte(8'h02);
    rst = 1'b1;
    tick(1);
    m_retry = 0;
    check("midrst_busy",  64'(bus.busy),  64'd0);
    check("midrst_image", 64'(bus.image), 64'd0);
    check("midrst_label", 64'(bus.label), 64'd0);
    check("midrst_out",   64'({bus.pkt_valid, bus.train, bus.resend, bus.err_csum,
                                bus.err_frame, bus.err_timeout}), 64'd0);
    rst = 1'b0;
    tick(1);
    build(8'hF0, 32'h11223344, 8'h55, 8'h00, 8'hBB); run_frame("postrst_bad", 0, 0);
    build(8'hF0, 32'hDEADBEEF, 8'h3C, ref_sum(32'hDEADBEEF, 8'h3C), 8'hBB); run_frame("postrst_good", 0, 0);

    // Randomized frames.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(3, 0) == 0) begin
        send_byte(8'($urandom_range(254, 0)));
        check($sformatf("rnd%0d_junk", k), 64'(bus.busy), 64'd0);
      end
      img  = IW'($urandom);
      lab  = 8'($urandom);
      mode = ($urandom_range(1, 0) == 1) ? 8'hF0 : 8'h0F;
      if ($urandom_range(9, 0) == 0) begin
        mode = 8'($urandom);
        while (mode == 8'hF0 || mode == 8'h0F) mode = 8'($urandom);
      end
      csum = ref_sum(img, lab);
      if ($urandom_range(3, 0) == 0) csum = csum + 8'($urandom_range(255, 1));
      stop = ($urandom_range(7, 0) == 0) ? 8'hAA : 8'hBB;
      run_frame($sformatf("rnd%0d", k), 3, ($urandom_range(2, 0) == 0) ? $urandom_range(6, 1) : 0);
    end

    check("pkt_stable", 64'(n_unstable), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 The block SHALL have parameter N_PIX, default 4, meaning the number of image bytes per frame (N_PIX >= 1).
REQ-002 The block SHALL have parameter MAX_RESEND, default 1, meaning the number of resend requests allowed per frame before it is dropped (>= 0).
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, meaning the maximum idle cycles between bytes inside a frame (>= 2).
REQ-004 uart_sampling_clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 data_rdy  in  1  uart_byte valid this cycle; one byte consumed per high cycle.
REQ-007 uart_byte  in  8  received byte.
REQ-008 pkt_ready  in  1  consumer accepts packet.
REQ-009 pkt_valid  out  1  image/label/train valid; held until accepted.
REQ-010 train  out  1  1 = TRAIN frame (0xF0), 0 = TEST frame (0x0F).
REQ-011 image  out  8*N_PIX  image bytes; first received byte in the MSBs.
REQ-012 label  out  8  label byte.
REQ-013 resend  out  1  one-cycle pulse requesting retransmission.
REQ-014 err_csum  out  1  one-cycle pulse: frame dropped after retries exhausted.
REQ-015 err_frame  out  1  one-cycle pulse: bad mode byte or missing STOP.
REQ-016 err_timeout  out  1  one-cycle pulse: inter-byte timeout.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 Frame format SHALL be START 0xFF, mode byte, N_PIX image bytes, label, checksum, STOP 0xBB.
REQ-019 Checksum SHALL be the 8-bit sum mod 256 of all image bytes plus the label byte.
REQ-020 The FSM SHALL have states IDLE, MODE, DATA, LABEL, CSUM, STOP, HOLD, and all transitions SHALL occur only on cycles with data_rdy=1, except timeout, handshake and reset.
REQ-021 IDLE: 0xFF SHALL move the FSM to MODE; any other byte SHALL be discarded silently.
REQ-022 MODE: 0xF0 SHALL set train=1 and move to DATA; 0x0F SHALL set train=0 and move to DATA; any other byte SHALL pulse err_frame and return to IDLE.
REQ-023 DATA: each byte SHALL be shifted into image from the LSB end; a byte counter SHALL move the FSM to LABEL after the N_PIX-th byte.
REQ-024 LABEL: the byte SHALL be captured into label, and the FSM SHALL move to CSUM.
REQ-025 CSUM: the received byte SHALL be compared with the running sum, the match flag SHALL be stored, and the FSM SHALL move to STOP.
REQ-026 STOP with byte != 0xBB SHALL pulse err_frame and go to IDLE, with no resend and the retry count unchanged.
REQ-027 STOP with byte 0xBB and checksum match SHALL raise pkt_valid on the next cycle, go to HOLD and clear the retry count.
REQ-028 STOP with byte 0xBB, checksum mismatch and retry count < MAX_RESEND SHALL pulse resend for one cycle, increment the retry count and go to IDLE.
REQ-029 STOP with byte 0xBB, checksum mismatch and retry count = MAX_RESEND SHALL pulse err_csum, clear the retry count and go to IDLE.
REQ-030 HOLD: pkt_valid=1 with image/label/train stable; pkt_valid&pkt_ready at an edge SHALL deassert pkt_valid the next cycle and return to IDLE.
REQ-031 HOLD: bytes arriving with data_rdy SHALL be dropped.
REQ-032 The inter-byte cycle counter SHALL reset on every data_rdy and at entry to MODE.
REQ-033 In MODE through STOP, TIMEOUT consecutive cycles without data_rdy SHALL pulse err_timeout, go to IDLE and leave the retry count unchanged.
REQ-034 The timeout SHALL NOT apply in IDLE or HOLD.
REQ-035 The running sum and byte counter SHALL clear on entry to MODE.
REQ-036 All outputs SHALL be registered.

Reset
REQ-037 rst=1 at an edge SHALL force IDLE, including mid-frame or in HOLD, and the partial frame SHALL be discarded.
REQ-038 While rst=1: pkt_valid, resend, err_csum, err_frame, err_timeout, busy, train = 0; image = 0; label = 0; retry count = 0; sum = 0; counters = 0.

Verification (N_PIX=4, MAX_RESEND=1, TIMEOUT=16)
REQ-039 FF F0 01 02 03 04 02 0C BB, pkt_ready=1 -> pkt_valid one cycle after BB; image=01020304, label=02, train=1.
REQ-040 Same frame with csum 0B -> resend pulse; repeat with csum 0A -> err_csum pulse, no second resend; third frame with 0C -> pkt_valid.
REQ-041 FF 55 -> err_frame, busy=0 next cycle; FF 0F 01 02 03 04 02 0C AA -> err_frame, no pkt_valid.
REQ-042 FF F0 01 then 16 idle cycles -> err_timeout pulse, state IDLE.
REQ-043 pkt_ready=0 for 5 cycles after a good frame -> pkt_valid and data held stable, bytes ignored; pkt_ready=1 -> pkt_valid low next cycle.
REQ-044 rst asserted after the 2nd image byte -> all outputs 0; a following good frame delivers correctly.
